// File: rtl/kronos_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU data port.
// Data wins by default; a starvation counter forces a fetch after STARVE_LIMIT data grants.
//
// state  | meaning
// IDLE   | no transaction locked; owner chosen combinationally each cycle
// BUSY_I | fetch transaction issued, waiting for mem_gnt
// BUSY_D | data transaction issued, waiting for mem_gnt
module kronos_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstz,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_gnt,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    output logic [31:0] data_rd_data,
    output logic        data_gnt,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       instr_waited;
    logic       instr_waited_nxt;

    logic data_req;
    logic sel_i;
    logic sel_d;
    logic fetch_waiting;

    assign data_req = data_rd_req | data_wr_req;
    assign sel_i    = instr_req & (~data_req | (starve_cnt == LIMIT));
    assign sel_d    = data_req & ~sel_i;

    // Whether fetch was pending when the current data transaction was selected.
    assign fetch_waiting = (state == IDLE) ? instr_req : instr_waited;

    always_comb begin
        owner = OWN_NONE;
        if (rstz) begin
            case (state)
                IDLE: begin
                    if (sel_i) begin
                        owner = OWN_I;
                    end else if (sel_d) begin
                        owner = OWN_D;
                    end
                end
                BUSY_I:  owner = OWN_I;
                BUSY_D:  owner = OWN_D;
                default: owner = OWN_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            instr_waited <= 1'b0;
        end else begin
            state        <= state_nxt;
            starve_cnt   <= starve_cnt_nxt;
            instr_waited <= instr_waited_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        starve_cnt_nxt   = starve_cnt;
        instr_waited_nxt = instr_waited;

        if (state == IDLE && !instr_req) begin
            starve_cnt_nxt = 4'd0;
        end

        if (owner != OWN_NONE) begin
            if (mem_gnt) begin
                state_nxt = IDLE;
                if (owner == OWN_I) begin
                    starve_cnt_nxt = 4'd0;
                end else if (fetch_waiting && (starve_cnt < LIMIT)) begin
                    starve_cnt_nxt = starve_cnt + 4'd1;
                end
            end else if (state == IDLE) begin
                state_nxt        = (owner == OWN_I) ? BUSY_I : BUSY_D;
                instr_waited_nxt = instr_req;
            end
        end
    end

    always_comb begin
        mem_addr    = 32'd0;
        mem_wr_data = 32'd0;
        mem_wr_mask = 4'd0;
        mem_wr_en   = 1'b0;
        case (owner)
            OWN_I: begin
                mem_addr = instr_addr;
            end
            OWN_D: begin
                mem_addr    = data_addr;
                mem_wr_data = data_wr_data;
                mem_wr_mask = data_wr_mask;
                mem_wr_en   = data_wr_req;
            end
            default: begin
            end
        endcase
    end

    assign mem_req      = rstz & ((state != IDLE) | instr_req | data_req);
    assign instr_gnt    = mem_gnt & (owner == OWN_I);
    assign data_gnt     = mem_gnt & (owner == OWN_D);
    assign instr_data   = mem_rd_data;
    assign data_rd_data = mem_rd_data;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Bench for kronos_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_kronos_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_gnt;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_wr_mask;
    logic        data_rd_req;
    logic        data_wr_req;
    logic [31:0] data_rd_data;
    logic        data_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic [31:0] mem_rd_data;
    logic        mem_gnt;

    int errors = 0;
    int checks = 0;

    // Model: which requester holds the port (0 none, 1 fetch, 2 data), the run of
    // data grants fetch has sat through, and whether fetch waited on the locked data access.
    int m_lock   = 0;
    int m_streak = 0;
    bit m_wait   = 1'b0;
    bit m_ig     = 1'b0;
    bit m_dg     = 1'b0;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rstz         (rstz),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .instr_gnt    (instr_gnt),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_wr_mask (data_wr_mask),
        .data_rd_req  (data_rd_req),
        .data_wr_req  (data_wr_req),
        .data_rd_data (data_rd_data),
        .data_gnt     (data_gnt),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_mask  (mem_wr_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_req      (mem_req),
        .mem_rd_data  (mem_rd_data),
        .mem_gnt      (mem_gnt)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model compare and update, once per cycle on the falling edge.
    always @(negedge clk) begin
        int          own;
        bit          dreq;
        bit          waited;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_mask;
        logic        e_we;
        logic        e_req;
        logic        e_ig;
        logic        e_dg;

        dreq = data_rd_req | data_wr_req;
        if (!rstz) begin
            m_lock   = 0;
            m_streak = 0;
            m_wait   = 1'b0;
            own      = 0;
            e_req    = 1'b0;
        end else begin
            if (m_lock != 0)
                own = m_lock;
            else if (instr_req && (!dreq || m_streak == LIMIT))
                own = 1;
            else if (dreq)
                own = 2;
            else
                own = 0;
            e_req = (m_lock != 0) || instr_req || dreq;
        end

        e_addr = (own == 1) ? instr_addr : (own == 2) ? data_addr : 32'd0;
        e_wd   = (own == 2) ? data_wr_data : 32'd0;
        e_mask = (own == 2) ? data_wr_mask : 4'd0;
        e_we   = (own == 2) && data_wr_req;
        e_ig   = mem_gnt && (own == 1);
        e_dg   = mem_gnt && (own == 2);

        chk1 ("m_mem_req",   mem_req,     e_req);
        chk32("m_mem_addr",  mem_addr,    e_addr);
        chk32("m_mem_wdata", mem_wr_data, e_wd);
        chk4 ("m_mem_mask",  mem_wr_mask, e_mask);
        chk1 ("m_mem_we",    mem_wr_en,   e_we);
        chk1 ("m_instr_gnt", instr_gnt,   e_ig);
        chk1 ("m_data_gnt",  data_gnt,    e_dg);
        if (e_ig) chk32("m_instr_data", instr_data, mem_rd_data);
        if (e_dg) chk32("m_data_rdata", data_rd_data, mem_rd_data);

        m_ig = e_ig;
        m_dg = e_dg;

        if (rstz) begin
            waited = (m_lock == 0) ? instr_req : m_wait;
            if (m_lock == 0 && !instr_req) m_streak = 0;
            if (own != 0 && mem_gnt) begin
                m_lock = 0;
                if (own == 1)
                    m_streak = 0;
                else if (waited && m_streak < LIMIT)
                    m_streak = m_streak + 1;
            end else if (own != 0 && m_lock == 0) begin
                m_lock = own;
                m_wait = instr_req;
            end
        end
    end

    initial begin
        bit ia;
        bit da;
        bit dw;

        rstz = 1'b0;
        instr_addr = '0; instr_req = 1'b0;
        data_addr = '0; data_wr_data = '0; data_wr_mask = '0;
        data_rd_req = 1'b0; data_wr_req = 1'b0;
        mem_rd_data = '0; mem_gnt = 1'b0;

        // Reset: requests and mem_gnt present but everything gated off.
        repeat (2) @(posedge clk);
        #1;
        instr_req = 1'b1; data_wr_req = 1'b1; mem_gnt = 1'b1;
        instr_addr = 32'h44; data_addr = 32'h88; data_wr_mask = 4'hF;
        @(negedge clk);
        chk1 ("rst_mem_req",   mem_req,   1'b0);
        chk1 ("rst_instr_gnt", instr_gnt, 1'b0);
        chk1 ("rst_data_gnt",  data_gnt,  1'b0);
        chk32("rst_mem_addr",  mem_addr,  32'h0);
        chk1 ("rst_mem_we",    mem_wr_en, 1'b0);
        chk4 ("rst_mem_mask",  mem_wr_mask, 4'h0);
        @(posedge clk); #1;
        instr_req = 1'b0; data_wr_req = 1'b0; mem_gnt = 1'b0; data_wr_mask = '0; rstz = 1'b1;

        // Stray mem_gnt with nobody requesting.
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk1("idle_gnt_i",   instr_gnt, 1'b0);
        chk1("idle_gnt_d",   data_gnt,  1'b0);
        chk1("idle_gnt_req", mem_req,   1'b0);

        // Fetch only, completion two cycles after the request.
        @(posedge clk); #1;
        mem_gnt = 1'b0; instr_req = 1'b1; instr_addr = 32'h100;
        @(negedge clk);
        chk1 ("f_req0",  mem_req,   1'b1);
        chk32("f_addr0", mem_addr,  32'h100);
        chk1 ("f_we0",   mem_wr_en, 1'b0);
        chk1 ("f_gnt0",  instr_gnt, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1 ("f_req1",  mem_req,   1'b1);
        chk32("f_addr1", mem_addr,  32'h100);
        chk1 ("f_gnt1",  instr_gnt, 1'b0);
        @(posedge clk); #1;
        mem_gnt = 1'b1; mem_rd_data = 32'h0000_0013;
        @(negedge clk);
        chk1 ("f_req2",  mem_req,    1'b1);
        chk1 ("f_gnt2",  instr_gnt,  1'b1);
        chk32("f_data",  instr_data, 32'h13);
        chk1 ("f_dgnt",  data_gnt,   1'b0);
        @(posedge clk); #1;
        instr_req = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        chk1("f_req3", mem_req, 1'b0);

        // Store completing in its selection cycle; FSM must stay IDLE.
        @(posedge clk); #1;
        data_wr_req = 1'b1; data_addr = 32'h2004; data_wr_data = 32'hAABB_CCDD;
        data_wr_mask = 4'b1100; mem_gnt = 1'b1;
        @(negedge clk);
        chk1 ("s_we",    mem_wr_en,   1'b1);
        chk4 ("s_mask",  mem_wr_mask, 4'b1100);
        chk32("s_addr",  mem_addr,    32'h2004);
        chk32("s_wdata", mem_wr_data, 32'hAABB_CCDD);
        chk1 ("s_gnt",   data_gnt,    1'b1);
        @(posedge clk); #1;
        data_wr_req = 1'b0; mem_gnt = 1'b0; instr_req = 1'b1; instr_addr = 32'h300;
        @(negedge clk);
        chk32("s_idle_addr", mem_addr,    32'h300);
        chk1 ("s_idle_we",   mem_wr_en,   1'b0);
        chk4 ("s_idle_mask", mem_wr_mask, 4'h0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk1("s_next_igrant", instr_gnt, 1'b1);
        @(posedge clk); #1;
        instr_req = 1'b0; mem_gnt = 1'b0; data_wr_mask = 4'h0;

        // Simultaneous fetch and load: data first, fetch after data's gnt.
        @(posedge clk); #1;
        instr_req = 1'b1; instr_addr = 32'h400; data_rd_req = 1'b1; data_addr = 32'h500;
        @(negedge clk);
        chk32("both_addr0", mem_addr, 32'h500);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk1 ("both_dgnt",  data_gnt,  1'b1);
        chk1 ("both_ign0",  instr_gnt, 1'b0);
        chk32("both_addr1", mem_addr,  32'h500);
        @(posedge clk); #1;
        data_rd_req = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        chk32("both_addr2", mem_addr,  32'h400);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk1("both_igrant", instr_gnt, 1'b1);
        @(posedge clk); #1;
        instr_req = 1'b0; mem_gnt = 1'b0;

        // Both held, memory completes every cycle: D D D D I D D D D I.
        @(posedge clk); #1;
        instr_req = 1'b1; data_rd_req = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk1("starve_i", instr_gnt, (i == 4 || i == 9));
            chk1("starve_d", data_gnt,  !(i == 4 || i == 9));
        end

        // Three more data grants with fetch waiting, then lock a load and reset mid-flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("pre_rst_d", data_gnt, 1'b1);
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        chk32("busy_d_addr", mem_addr, 32'h500);
        @(posedge clk); #1;
        @(negedge clk);
        chk1 ("busy_d_req",   mem_req,  1'b1);
        chk32("busy_d_addr1", mem_addr, 32'h500);
        @(posedge clk); #1;
        rstz = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk1 ("midrst_req",  mem_req,   1'b0);
        chk1 ("midrst_dgnt", data_gnt,  1'b0);
        chk1 ("midrst_ignt", instr_gnt, 1'b0);
        chk32("midrst_addr", mem_addr,  32'h0);
        @(posedge clk); #1;
        rstz = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk1("postrst_d", data_gnt,  (i < 4));
            chk1("postrst_i", instr_gnt, (i == 4));
        end
        @(posedge clk); #1;
        instr_req = 1'b0; data_rd_req = 1'b0; mem_gnt = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        ia = 1'b0; da = 1'b0; dw = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (!rstz)
                rstz = 1'b1;
            else if ($urandom_range(0, 399) == 0)
                rstz = 1'b0;
            if (ia && m_ig) ia = 1'b0;
            if (da && m_dg) da = 1'b0;
            if (!ia && $urandom_range(0, 2) == 0) begin
                ia = 1'b1;
                instr_addr = $urandom;
            end
            if (!da && $urandom_range(0, 1) == 0) begin
                da = 1'b1;
                dw = 1'($urandom_range(0, 1));
                data_addr    = $urandom;
                data_wr_data = $urandom;
                data_wr_mask = 4'($urandom_range(0, 15));
            end
            instr_req   = ia;
            data_rd_req = da & ~dw;
            data_wr_req = da & dw;
            mem_gnt     = ($urandom_range(0, 2) == 0);
            mem_rd_data = $urandom;
        end

        @(posedge clk); #1;
        instr_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0; mem_gnt = 1'b0; rstz = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
